eeprom_cmd_sequencer: RTL
=========================

# eeprom_cmd_sequencer

- Sequences one N64 EEPROM block transfer (8 bytes, block 0–255) through the byte-wide register bus of the EEPROM interface core.
- Master side: sits between the PIF command decoder and that core's register port.
- Per request it programs command, address and byte count, clears the FIFOs, pushes write data, enables the transfer, polls status to completion, and drains read data back to the requester.

## Interface
Parameters:
- DEV_ADDR, 7'h50: I2C device address; command byte is {DEV_ADDR, rw}, with rw=1 for read.
- POLL_TIMEOUT, 24'd10_000_000: `clk` cycles allowed from enable to completion before the transfer is abandoned.

Ports:
- clk  in  1  system clock.
- reset_l  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write block, 0 = read block.
- req_block  in  8  EEPROM block number.
- wr_data  in  8  write byte stream.
- wr_valid  in  1  write byte present.
- wr_ready  out  1  write byte accepted this cycle.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle strobe per read byte; no backpressure.
- done  out  1  one-cycle pulse, transfer complete.
- error  out  1  one-cycle pulse, timeout.
- busy  out  1  state != IDLE.
- bus_address  out  4  core register offset.
- bus_wdata  out  8  core write data.
- bus_write  out  1  1 = write access.
- bus_ce  out  1  access strobe, one cycle per access.
- bus_valid  in  1  core valid; asserted the cycle after bus_ce.
- bus_rdata  in  8  core read data; sampled when bus_valid=1 after a read.

## Operation
- Register map (offsets): 0 cmd, 1 addr_hi, 2 addr_lo, 3 byte_count, 4 status (read), 5 control (write), 6 read-FIFO pop, 7 write-FIFO push.
- Status bits: [4] ready, [3] processing.
- Control bits: [2] clear write FIFO, [1] clear read FIFO, [0] enable.
- Address: byte address = req_block×8; addr_hi = {5'b0, req_block[7:5]}; addr_lo = {req_block[4:0], 3'b000}. byte_count = 8.
- States:
  - IDLE: req_valid && req_ready → latch request → SETUP.
  - SETUP: four bus writes, offsets 0,1,2,3 in order → CLEAR.
  - CLEAR: write offset 5 = 8'h06 → PUSH if write, else ENABLE.
  - PUSH: wr_ready=1; each accepted byte is written to offset 7 the next cycle. After 8 bytes → ENABLE. Underrun (wr_valid low) stalls without timeout.
  - ENABLE: write offset 5 = 8'h01; clear timeout counter and seen_busy → POLL.
  - POLL: read offset 4 repeatedly. A read with processing=1 sets seen_busy. Completion is seen_busy && ready=1 && processing=0. On completion → DRAIN if read, else FIN.
  - DRAIN: 8 reads of offset 6; each captured byte is presented on rd_data with rd_valid=1 in the capture cycle → FIN.
  - FIN: done=1 → IDLE.
- Timeout counter runs in POLL. Reaching POLL_TIMEOUT → write offset 5 = 8'h00, pulse error, → IDLE. done is not pulsed.
- Request fields are ignored outside IDLE. wr_valid is ignored outside PUSH.

## Timing
- Reset values:
  - state IDLE.
  - req_ready=1.
  - All other outputs 0, including bus_address, bus_wdata and rd_data.
- Bus writes: one cycle each, back-to-back allowed.
- Bus reads: bus_ce in cycle N; bus_rdata captured in cycle N+1 with bus_valid. The next access issues no earlier than N+2.
- Request accepted in cycle T: the first SETUP write is on the bus at T+1. The CLEAR write is at T+5.
- Read transfer with the first completing poll at cycle P: DRAIN reads at P+2, P+4, …, P+16. rd_valid at P+3, P+5, …, P+17. done at P+18.
- bus_ce high with bus_valid low in the following cycle: the access is retried in the next cycle. No other retry path exists.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. The core is not notified; the next request's CLEAR recovers the FIFOs.

## Structure
- Package eeprom_seq_pkg holds:
  - register offset localparams;
  - status/control bit positions;
  - CTRL_CLEAR=8'h06, CTRL_EN=8'h01, CTRL_OFF=8'h00;
  - the state enum;
  - BLOCK_BYTES=8.
- One natural sub-module, eeprom_bus_access: a single-access engine with start/offset/wdata/rw in and ack/rdata out, covering the bus_ce/bus_valid handshake. The FSM above sequences it.

## Test plan
- Read of block 8'h25:
  - Bus writes exactly: 0←8'hA1, 1←8'h01, 2←8'h28, 3←8'h08, 5←8'h06, 5←8'h01.
  - Polls return processing=1, then ready=1/processing=0.
  - Reads of offset 6 return 8'h10..8'h17 → 8 rd_valid strobes, then done.
- Write of block 8'h00 with data 8'hA0..8'hA7, wr_valid toggling every other cycle:
  - Eight offset-7 writes with that data in order, before the 5←8'h01 write.
  - No offset-6 reads; done after completion.
- Status held at processing=1 for POLL_TIMEOUT cycles (POLL_TIMEOUT overridden to 100) → write 5←8'h00, error pulse, no done, req_ready=1.
- Status ready=1/processing=0 on the first poll (seen_busy clear) → polling continues. Completion is only reported after a processing=1 poll.
- reset_l low during DRAIN (after 3 bytes):
  - All outputs 0 immediately.
  - A following read request restarts cleanly from the SETUP writes.
- req_valid held high across two back-to-back requests → second accepted only after done, at the first IDLE cycle.

Source files
------------

// File: rtl/eeprom_seq_pkg.sv
// Shared register map, control/status encodings and FSM states for the
// N64 EEPROM block-transfer sequencer.
package eeprom_seq_pkg;

    localparam logic [3:0] REG_CMD      = 4'd0;
    localparam logic [3:0] REG_ADDR_HI  = 4'd1;
    localparam logic [3:0] REG_ADDR_LO  = 4'd2;
    localparam logic [3:0] REG_BYTE_CNT = 4'd3;
    localparam logic [3:0] REG_STATUS   = 4'd4;
    localparam logic [3:0] REG_CONTROL  = 4'd5;
    localparam logic [3:0] REG_RD_POP   = 4'd6;
    localparam logic [3:0] REG_WR_PUSH  = 4'd7;

    localparam int STAT_READY  = 4;
    localparam int STAT_PROC   = 3;
    localparam int CTRL_CLR_WR = 2;
    localparam int CTRL_CLR_RD = 1;
    localparam int CTRL_ENABLE = 0;

    localparam logic [7:0] CTRL_CLEAR = 8'((1 << CTRL_CLR_WR) | (1 << CTRL_CLR_RD));
    localparam logic [7:0] CTRL_EN    = 8'(1 << CTRL_ENABLE);
    localparam logic [7:0] CTRL_OFF   = 8'h00;

    localparam int BLOCK_BYTES = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLEAR,
        ST_PUSH,
        ST_ENABLE,
        ST_POLL,
        ST_DRAIN,
        ST_FIN,
        ST_ABORT
    } state_t;

    // Byte written to each of the four setup registers for a given block.
    function automatic logic [7:0] setup_byte(input logic [3:0] off, input logic [6:0] dev,
                                              input logic rd, input logic [7:0] blk);
        case (off)
            REG_CMD:      return {dev, rd};
            REG_ADDR_HI:  return {5'b0, blk[7:5]};
            REG_ADDR_LO:  return {blk[4:0], 3'b000};
            REG_BYTE_CNT: return 8'(BLOCK_BYTES);
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/eeprom_cmd_sequencer_bus_access.sv
// Single-access engine for the core register port: issues one bus_ce per
// access, waits for bus_valid and reissues any access the core did not take.
module eeprom_bus_access (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       start,
    input  logic [3:0] offset,
    input  logic [7:0] wdata,
    input  logic       rw,
    output logic       ack,
    output logic [7:0] rdata,
    output logic [3:0] bus_address,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    output logic       bus_ce,
    input  logic       bus_valid,
    input  logic [7:0] bus_rdata
);

    logic       wait_q;
    logic       saved_rd_q;
    logic [3:0] saved_off_q;
    logic [7:0] saved_wdata_q;
    logic       retry;
    logic       issue;

    // Writes are posted (acked on issue); reads ack when their data returns,
    // and the cycle carrying read data never issues a new access.
    always_comb begin
        retry       = wait_q && !bus_valid;
        issue       = start && (!wait_q || (bus_valid && !saved_rd_q));
        bus_ce      = retry || issue;
        bus_address = 4'h0;
        bus_wdata   = 8'h00;
        bus_write   = 1'b0;
        if (retry) begin
            bus_address = saved_off_q;
            bus_wdata   = saved_rd_q ? 8'h00 : saved_wdata_q;
            bus_write   = !saved_rd_q;
        end else if (issue) begin
            bus_address = offset;
            bus_wdata   = rw ? 8'h00 : wdata;
            bus_write   = !rw;
        end
        ack   = (issue && !rw) || (start && rw && wait_q && saved_rd_q && bus_valid);
        rdata = bus_rdata;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wait_q        <= 1'b0;
            saved_rd_q    <= 1'b0;
            saved_off_q   <= 4'h0;
            saved_wdata_q <= 8'h00;
        end else begin
            wait_q <= bus_ce;
            if (issue) begin
                saved_rd_q    <= rw;
                saved_off_q   <= offset;
                saved_wdata_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/eeprom_cmd_sequencer.sv
// Sequences one 8-byte N64 EEPROM block transfer through the byte-wide
// register port of the EEPROM interface core.
module eeprom_cmd_sequencer
    import eeprom_seq_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR     = 7'h50,
    parameter logic [23:0] POLL_TIMEOUT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_block,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       error,
    output logic       busy,
    output logic [3:0] bus_address,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    output logic       bus_ce,
    input  logic       bus_valid,
    input  logic [7:0] bus_rdata
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  take_q, take_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  buf_q, buf_d;
    logic        write_q, write_d;
    logic [7:0]  block_q, block_d;
    logic [23:0] timer_q, timer_d;
    logic        seen_busy_q, seen_busy_d;

    logic        start;
    logic [3:0]  acc_off;
    logic [7:0]  acc_wdata;
    logic        acc_rw;
    logic        ack;
    logic [7:0]  rdata;

    eeprom_bus_access u_access (
        .clk         (clk),
        .reset_l     (reset_l),
        .start       (start),
        .offset      (acc_off),
        .wdata       (acc_wdata),
        .rw          (acc_rw),
        .ack         (ack),
        .rdata       (rdata),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_write   (bus_write),
        .bus_ce      (bus_ce),
        .bus_valid   (bus_valid),
        .bus_rdata   (bus_rdata)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        take_d      = take_q;
        buf_full_d  = buf_full_q;
        buf_d       = buf_q;
        write_d     = write_q;
        block_d     = block_q;
        timer_d     = timer_q;
        seen_busy_d = seen_busy_q;
        start       = 1'b0;
        acc_off     = 4'h0;
        acc_wdata   = 8'h00;
        acc_rw      = 1'b0;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    block_d = req_block;
                    idx_d   = 4'd0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                start     = 1'b1;
                acc_off   = idx_q;
                acc_wdata = setup_byte(idx_q, DEV_ADDR, !write_q, block_q);
                if (ack) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == REG_BYTE_CNT) state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                start     = 1'b1;
                acc_off   = REG_CONTROL;
                acc_wdata = CTRL_CLEAR;
                if (ack) begin
                    idx_d      = 4'd0;
                    take_d     = 4'd0;
                    buf_full_d = 1'b0;
                    state_d    = write_q ? ST_PUSH : ST_ENABLE;
                end
            end
            ST_PUSH: begin
                // One-byte skid: a byte taken this cycle goes to the core next cycle.
                start     = buf_full_q;
                acc_off   = REG_WR_PUSH;
                acc_wdata = buf_q;
                wr_ready  = (take_q != 4'(BLOCK_BYTES)) && (!buf_full_q || ack);
                if (wr_valid && wr_ready) begin
                    buf_d      = wr_data;
                    buf_full_d = 1'b1;
                    take_d     = take_q + 4'd1;
                end else if (ack) begin
                    buf_full_d = 1'b0;
                end
                if (ack) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(BLOCK_BYTES - 1)) state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                start       = 1'b1;
                acc_off     = REG_CONTROL;
                acc_wdata   = CTRL_EN;
                timer_d     = 24'd0;
                seen_busy_d = 1'b0;
                if (ack) state_d = ST_POLL;
            end
            ST_POLL: begin
                // A ready status only counts once the core has been seen processing.
                start   = 1'b1;
                acc_off = REG_STATUS;
                acc_rw  = 1'b1;
                timer_d = timer_q + 24'd1;
                if (ack && rdata[STAT_PROC]) seen_busy_d = 1'b1;
                if (ack && seen_busy_q && rdata[STAT_READY] && !rdata[STAT_PROC]) begin
                    idx_d   = 4'd0;
                    state_d = write_q ? ST_FIN : ST_DRAIN;
                end else if (timer_q >= POLL_TIMEOUT) begin
                    state_d = ST_ABORT;
                end
            end
            ST_DRAIN: begin
                start    = 1'b1;
                acc_off  = REG_RD_POP;
                acc_rw   = 1'b1;
                rd_valid = ack;
                if (ack) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(BLOCK_BYTES - 1)) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                start     = 1'b1;
                acc_off   = REG_CONTROL;
                acc_wdata = CTRL_OFF;
                if (ack) begin
                    error   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_data = rd_valid ? rdata : 8'h00;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            take_q      <= 4'd0;
            buf_full_q  <= 1'b0;
            buf_q       <= 8'h00;
            write_q     <= 1'b0;
            block_q     <= 8'h00;
            timer_q     <= 24'd0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            take_q      <= take_d;
            buf_full_q  <= buf_full_d;
            buf_q       <= buf_d;
            write_q     <= write_d;
            block_q     <= block_d;
            timer_q     <= timer_d;
            seen_busy_q <= seen_busy_d;
        end
    end

endmodule
